// File: rtl/systolic_skew_feeder.sv
// Operand feeder for the NxN systolic array: skews A columns / B rows so that
// lane i arrives i cycles late, and sequences clear -> stream -> drain -> done.

module systolic_skew_lane #(
    parameter int DW    = 16,
    parameter int DEPTH = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);
    logic [DEPTH-1:0][DW-1:0] pipe_q, pipe_d;

    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = din;
        for (int k = 1; k < DEPTH; k++) pipe_d[k] = pipe_q[k-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe_q <= '0;
        else        pipe_q <= pipe_d;
    end

    assign dout = pipe_q[DEPTH-1];
endmodule

module systolic_skew_feeder #(
    parameter int N         = 32,
    parameter int DW        = 16,
    parameter int KW        = 10,
    parameter int DRAIN_CYC = 3*(N-1)+1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [KW-1:0] k_len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N*DW-1:0] a_col_in,
    input  logic [N*DW-1:0] b_row_in,
    output logic [N*DW-1:0] a_west,
    output logic [N*DW-1:0] b_north,
    output logic          acc_clr,
    output logic          busy,
    output logic          done
);
    localparam int DCW = $clog2(DRAIN_CYC + 1);

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [KW-1:0]  klen_q, klen_d;
    logic [KW-1:0]  beat_q, beat_d;
    logic [DCW-1:0] drain_q, drain_d;

    logic           accept;
    logic [N*DW-1:0] a_slice, b_slice;

    assign in_ready = (state_q == S_STREAM);
    assign acc_clr  = (state_q == S_CLR);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign accept   = in_valid && in_ready;

    // Non-accepted slots enter as zero in both operands, so the product stays 0
    // and A/B alignment in the array is preserved without stalling.
    assign a_slice = accept ? a_col_in : '0;
    assign b_slice = accept ? b_row_in : '0;

    always_comb begin
        state_d = state_q;
        klen_d  = klen_q;
        beat_d  = beat_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (start && (k_len != '0)) begin
                    state_d = S_CLR;
                    klen_d  = k_len;
                    beat_d  = '0;
                end
            end
            S_CLR: state_d = S_STREAM;
            S_STREAM: begin
                if (accept) begin
                    beat_d = beat_q + KW'(1);
                    if (beat_q == klen_q - KW'(1)) begin
                        state_d = S_DRAIN;
                        drain_d = '0;
                    end
                end
            end
            // Holds one cycle past DRAIN_CYC so done lands after the array's
            // last sum register has settled.
            S_DRAIN: begin
                if (drain_q == DCW'(DRAIN_CYC)) state_d = S_DONE;
                else                            drain_d = drain_q + DCW'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            klen_q  <= '0;
            beat_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            klen_q  <= klen_d;
            beat_q  <= beat_d;
            drain_q <= drain_d;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        systolic_skew_lane #(.DW(DW), .DEPTH(i+1)) u_a (
            .clk  (clk),
            .rst_n(rst_n),
            .din  (a_slice[i*DW +: DW]),
            .dout (a_west[i*DW +: DW])
        );
        systolic_skew_lane #(.DW(DW), .DEPTH(i+1)) u_b (
            .clk  (clk),
            .rst_n(rst_n),
            .din  (b_slice[i*DW +: DW]),
            .dout (b_north[i*DW +: DW])
        );
    end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder: driver records the slice it expects
// to enter each cycle plus expected done times; a negedge monitor compares.

module tb_systolic_skew_feeder;
    localparam int N    = 32;
    localparam int DW   = 16;
    localparam int KW   = 10;
    localparam int D    = 3*(N-1)+1;
    localparam int HIST = 2048;

    logic            clk = 0;
    logic            rst_n;
    logic            start;
    logic [KW-1:0]   k_len;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] a_in, b_in, a_west, b_north;
    logic            acc_clr, busy, done;

    systolic_skew_feeder #(.N(N), .DW(DW), .KW(KW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_col_in(a_in), .b_row_in(b_in),
        .a_west(a_west), .b_north(b_north),
        .acc_clr(acc_clr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [N*DW-1:0] ent_a [HIST];
    logic [N*DW-1:0] ent_b [HIST];
    logic [2:0]      exp_ctl [HIST];   // {in_ready, acc_clr, busy}
    int              done_q[$];
    int              base = 0;
    bit              mon_en = 0;
    int              errors = 0;
    int              checks = 0;

    task automatic step(input logic rdy, input logic clr, input logic bsy);
        if (cyc >= HIST) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, HIST);
            $fatal(1);
        end
        exp_ctl[cyc] = {rdy, clr, bsy};
        ent_a[cyc]   = (rdy && in_valid) ? a_in : '0;
        ent_b[cyc]   = (rdy && in_valid) ? b_in : '0;
        @(posedge clk); #1;
    endtask

    task automatic rand_slice();
        logic [7:0] r;
        for (int i = 0; i < N; i++) begin
            r = 8'($urandom);
            a_in[i*DW +: DW] = {{8{r[7]}}, r};
            r = 8'($urandom);
            b_in[i*DW +: DW] = {{8{r[7]}}, r};
        end
    endtask

    // abort_after >= 0: reset is asserted once that many beats were accepted.
    task automatic run_tile(input int k, input logic [63:0] bub, input int abort_after,
                            input bit poke, input bit pattern);
        int acc, slot, first;
        start = 1; k_len = KW'(k); in_valid = 0;
        step(0, 0, 0);
        start = 0;
        in_valid = 1; rand_slice();            // offered during CLR, must be ignored
        step(0, 1, 1);
        acc = 0; slot = 0; first = cyc;
        while (acc < k) begin
            if (abort_after >= 0 && acc == abort_after) begin
                rst_n = 0; in_valid = 0; start = 0; base = cyc;
                step(0, 0, 0);
                step(0, 0, 0);
                rst_n = 1;
                step(0, 0, 0);
                return;
            end
            in_valid = !bub[slot];
            if (pattern) begin
                for (int i = 0; i < N; i++) begin
                    a_in[i*DW +: DW] = DW'(i + 1);
                    b_in[i*DW +: DW] = DW'(16'h100 + i);
                end
            end else rand_slice();
            start = poke && (slot == 5);
            k_len = start ? KW'(3) : KW'(k);
            step(1, 0, 1);
            if (in_valid) acc++;
            slot++;
        end
        start = 0;
        done_q.push_back(first + slot + D + 1);
        for (int c = 0; c <= D; c++) begin
            in_valid = 1; rand_slice();
            step(0, 0, 1);
        end
        in_valid = 0;
        step(0, 0, 1);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            logic [N*DW-1:0] ea, eb;
            int idx;
            ea = '0; eb = '0;
            for (int i = 0; i < N; i++) begin
                idx = cyc - 1 - i;
                if (idx >= base) begin
                    ea[i*DW +: DW] = ent_a[idx][i*DW +: DW];
                    eb[i*DW +: DW] = ent_b[idx][i*DW +: DW];
                end
            end
            checks++;
            if ({in_ready, acc_clr, busy} !== exp_ctl[cyc]) begin
                errors++;
                $display("FAIL ctrl cyc=%0d got rdy/clr/busy=%b want %b", cyc,
                         {in_ready, acc_clr, busy}, exp_ctl[cyc]);
            end
            checks++;
            if (a_west !== ea) begin
                errors++;
                $display("FAIL a_west cyc=%0d got %h want %h", cyc, a_west, ea);
            end
            checks++;
            if (b_north !== eb) begin
                errors++;
                $display("FAIL b_north cyc=%0d got %h want %h", cyc, b_north, eb);
            end
            if (done === 1'b1) begin
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_spurious cyc=%0d got done=1 want 0", cyc);
                end else begin
                    int e;
                    e = done_q.pop_front();
                    if (e != cyc) begin
                        errors++;
                        $display("FAIL done_time got cyc=%0d want cyc=%0d", cyc, e);
                    end
                end
            end else if (done !== 1'b0) begin
                checks++; errors++;
                $display("FAIL done_x cyc=%0d got %b want 0/1", cyc, done);
            end
        end
    end

    initial begin
        for (int i = 0; i < HIST; i++) begin
            ent_a[i] = '0; ent_b[i] = '0; exp_ctl[i] = '0;
        end
        rst_n = 0; start = 0; k_len = '0; in_valid = 0; a_in = '0; b_in = '0;
        @(posedge clk); #1;
        mon_en = 1;
        for (int c = 0; c < 4; c++) begin
            start = 1'($urandom); k_len = KW'($urandom); in_valid = 1'($urandom);
            rand_slice();
            step(0, 0, 0);
        end
        rst_n = 1; start = 0; in_valid = 0; a_in = '0; b_in = '0;
        step(0, 0, 0);
        step(0, 0, 0);

        // zero-length start is ignored
        start = 1; k_len = '0;
        step(0, 0, 0);
        start = 0;
        for (int c = 0; c < 3; c++) step(0, 0, 0);

        run_tile(1, 64'd0, -1, 0, 1);
        run_tile(32, 64'd0, -1, 0, 0);
        run_tile(32, (64'd1 << 3) | (64'd1 << 4) | (64'd1 << 17), -1, 0, 0);
        run_tile(8, 64'd0, -1, 1, 0);
        run_tile(32, 64'd0, 10, 0, 0);
        run_tile(32, 64'd0, -1, 0, 0);
        for (int c = 0; c < 5; c++) step(0, 0, 0);

        checks++;
        if (done_q.size() != 0) begin
            errors++;
            $display("FAIL done_missing got %0d outstanding want 0", done_q.size());
        end
        mon_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
